wb_write_queue: RTL

- Writeback-side initiator for the 32x32 register file write port (addwr/datawr/write_enable).
- Accepts results from the ALU path and the load (MEM) path through valid/ready handshakes and buffers them in an in-order FIFO.
- Issues at most one register-file write per cycle.
- Provides forwarding lookup on the two read addresses, so pending writes are visible before they reach the register file.

---
 rtl/wb_write_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_write_queue.sv
// Writeback write queue: buffers ALU and load results in order and drains
// one register-file write per cycle, with forwarding of pending writes.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_addr,
    input  logic [DW-1:0]          alu_data,
    output logic [AW-1:0]          addwr,
    output logic [DW-1:0]          datawr,
    output logic                   write_enable,
    input  logic [AW-1:0]          add1,
    input  logic [AW-1:0]          add2,
    output logic                   fwd_hit1,
    output logic [DW-1:0]          fwd_data1,
    output logic                   fwd_hit2,
    output logic [DW-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ROOM2_C  = CW'(DEPTH - 2);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wq_entry_t;

    wq_entry_t       q [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   alu_slot;
    logic            mem_fire;
    logic            alu_fire;
    logic            mem_push;
    logic            alu_push;
    logic            pop;
    logic [1:0]      npush;
    logic [DW:0]     look1;
    logic [DW:0]     look2;

    // Ready depends only on the current count; a same-cycle pop frees nothing.
    assign mem_ready = (count < DEPTH_C);
    assign alu_ready = (count <= ROOM2_C) || (!mem_valid && (count < DEPTH_C));

    assign mem_fire = mem_valid && mem_ready && !reset;
    assign alu_fire = alu_valid && alu_ready && !reset;
    assign mem_push = mem_fire && (mem_addr != '0);
    assign alu_push = alu_fire && (alu_addr != '0);
    assign pop      = (count != '0);
    assign npush    = {1'b0, mem_push} + {1'b0, alu_push};
    assign alu_slot = wr_ptr + PW'(mem_push);

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (mem_push) begin
            q[wr_ptr] <= '{addr: mem_addr, data: mem_data};
        end
        if (alu_push) begin
            q[alu_slot] <= '{addr: alu_addr, data: alu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            write_enable <= 1'b0;
            addwr        <= '0;
            datawr       <= '0;
        end else begin
            count  <= count + CW'(npush) - CW'(pop);
            wr_ptr <= wr_ptr + PW'(npush);
            if (pop) begin
                rd_ptr       <= rd_ptr + PW'(1);
                addwr        <= q[rd_ptr].addr;
                datawr       <= q[rd_ptr].data;
                write_enable <= 1'b1;
            end else begin
                write_enable <= 1'b0;
            end
        end
    end

    // Oldest to newest, so the youngest match overrides; output register first.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic          hit;
        logic [DW-1:0] d;
        logic [PW-1:0] idx;
        hit = 1'b0;
        d   = '0;
        idx = '0;
        if (write_enable && (addwr == a)) begin
            hit = 1'b1;
            d   = datawr;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (q[idx].addr == a)) begin
                hit = 1'b1;
                d   = q[idx].data;
            end
        end
        if (a == '0) begin
            hit = 1'b0;
            d   = '0;
        end
        return {hit, d};
    endfunction

    always_comb begin
        look1 = lookup(add1);
        look2 = lookup(add2);
    end

    assign fwd_hit1  = look1[DW];
    assign fwd_data1 = look1[DW-1:0];
    assign fwd_hit2  = look2[DW];
    assign fwd_data2 = look2[DW-1:0];

endmodule
